// File: rtl/maze_pkg.sv
// Shared types and heading helpers for the maze walker.
// Headings are N=0 E=1 S=2 W=3; all turn arithmetic is mod 4.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_PROBE_SIDE,
    S_EVAL_SIDE,
    S_PROBE_FRONT,
    S_EVAL_FRONT,
    S_DONE,
    S_FAIL
  } state_t;

  // hand=0: right-hand rule, hand=1: left-hand rule
  function automatic dir_t turn_side(dir_t d, logic hand);
    return hand ? dir_t'(d - 2'd1) : dir_t'(d + 2'd1);
  endfunction

  function automatic dir_t turn_away(dir_t d, logic hand);
    return hand ? dir_t'(d + 2'd1) : dir_t'(d - 2'd1);
  endfunction

endpackage

// File: rtl/maze_neighbor.sv
// Combinational neighbour address: (row, col, dir) -> (nb_row, nb_col).
// Ports: row/col in, dir heading in, nb_row/nb_col out.
module maze_neighbor
  import maze_pkg::*;
#(
  parameter int ROW_W = 6,
  parameter int COL_W = 6
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  dir_t             dir,
  output logic [ROW_W-1:0] nb_row,
  output logic [COL_W-1:0] nb_col
);

  always_comb begin
    nb_row = row;
    nb_col = col;
    unique case (dir)
      DIR_N: nb_row = row - ROW_W'(1);
      DIR_E: nb_col = col + COL_W'(1);
      DIR_S: nb_row = row + ROW_W'(1);
      DIR_W: nb_col = col - COL_W'(1);
    endcase
  end

endmodule

// File: rtl/maze_walker.sv
// Wall-follower maze solver driving a synchronous 1-bit maze memory.
// Ports: clk/rst, start + start params, maze_in; row/col/oe/we, busy/done/fail/step_count.
module maze_walker
  import maze_pkg::*;
#(
  parameter int ROW_W     = 6,
  parameter int COL_W     = 6,
  parameter int MAZE_ROWS = 64,
  parameter int MAZE_COLS = 64,
  parameter int STEP_W    = 12,
  parameter int MAX_STEPS = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  starting_row,
  input  logic [COL_W-1:0]  starting_col,
  input  logic [1:0]        start_dir,
  input  logic              hand_sel,
  input  logic              maze_in,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              maze_oe,
  output logic              maze_we,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [STEP_W-1:0] step_count
);

  localparam logic [ROW_W:0]    ROW_LIM  = (ROW_W+1)'(MAZE_ROWS);
  localparam logic [COL_W:0]    COL_LIM  = (COL_W+1)'(MAZE_COLS);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(MAZE_ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(MAZE_COLS - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   cur_row_q, cur_row_d;
  logic [COL_W-1:0]   cur_col_q, cur_col_d;
  dir_t               dir_q, dir_d;
  logic               hand_q, hand_d;
  logic [1:0]         turn_q, turn_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               done_d, fail_d;
  logic [ROW_W-1:0]   row_d;
  logic [COL_W-1:0]   col_d;
  logic               oe_d, we_d, busy_d;

  dir_t               side_dir;
  dir_t               nb_dir;
  logic [ROW_W-1:0]   nb_row;
  logic [COL_W-1:0]   nb_col;
  logic               on_border;
  logic               oob;

  assign side_dir  = turn_side(dir_q, hand_q);
  assign on_border = (cur_row_q == '0) || (cur_row_q == LAST_ROW) ||
                     (cur_col_q == '0) || (cur_col_q == LAST_COL);
  assign oob = ({1'b0, starting_row} >= ROW_LIM) ||
               ({1'b0, starting_col} >= COL_LIM);

  // One neighbour unit serves both the next probe address and the
  // move target; the heading it sees depends on where we go next.
  always_comb begin
    nb_dir = side_dir;
    unique case (state_q)
      S_EVAL_SIDE:  nb_dir = maze_in ? dir_q : side_dir;
      S_EVAL_FRONT: nb_dir = maze_in ?
                      turn_side(turn_away(dir_q, hand_q), hand_q) : dir_q;
      default:      nb_dir = side_dir;
    endcase
  end

  maze_neighbor #(
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_nb (
    .row    (cur_row_q),
    .col    (cur_col_q),
    .dir    (nb_dir),
    .nb_row (nb_row),
    .nb_col (nb_col)
  );

  always_comb begin
    state_d   = state_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    dir_d     = dir_q;
    hand_d    = hand_q;
    turn_d    = turn_q;
    step_d    = step_q;
    done_d    = done;
    fail_d    = fail;
    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          done_d    = 1'b0;
          fail_d    = 1'b0;
          step_d    = '0;
          turn_d    = '0;
          cur_row_d = starting_row;
          cur_col_d = starting_col;
          dir_d     = dir_t'(start_dir);
          hand_d    = hand_sel;
          if (oob) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = S_MARK;
          end
        end
      end
      S_MARK: begin
        if (on_border) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_PROBE_SIDE;
        end
      end
      S_PROBE_SIDE:  state_d = S_EVAL_SIDE;
      S_PROBE_FRONT: state_d = S_EVAL_FRONT;
      S_EVAL_SIDE: begin
        if (maze_in) begin
          state_d = S_PROBE_FRONT;
        end else if (step_q == STEP_MAX) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end else begin
          state_d   = S_MARK;
          dir_d     = side_dir;
          cur_row_d = nb_row;
          cur_col_d = nb_col;
          step_d    = step_q + STEP_W'(1);
          turn_d    = '0;
        end
      end
      S_EVAL_FRONT: begin
        if (maze_in) begin
          dir_d  = turn_away(dir_q, hand_q);
          turn_d = turn_q + 2'd1;
          if (turn_q == 2'd2) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = S_PROBE_SIDE;
          end
        end else if (step_q == STEP_MAX) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end else begin
          state_d   = S_MARK;
          cur_row_d = nb_row;
          cur_col_d = nb_col;
          step_d    = step_q + STEP_W'(1);
          turn_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side outputs are registered against the state being entered,
  // so they line up with that state's cycle.
  always_comb begin
    we_d   = (state_d == S_MARK);
    oe_d   = (state_d == S_PROBE_SIDE) || (state_d == S_PROBE_FRONT);
    busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) ||
               (state_d == S_FAIL));
    row_d  = row;
    col_d  = col;
    if (we_d) begin
      row_d = cur_row_d;
      col_d = cur_col_d;
    end else if (oe_d) begin
      row_d = nb_row;
      col_d = nb_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      dir_q      <= DIR_N;
      hand_q     <= 1'b0;
      turn_q     <= '0;
      step_q     <= '0;
      row        <= '0;
      col        <= '0;
      maze_oe    <= 1'b0;
      maze_we    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      dir_q      <= dir_d;
      hand_q     <= hand_d;
      turn_q     <= turn_d;
      step_q     <= step_d;
      row        <= row_d;
      col        <= col_d;
      maze_oe    <= oe_d;
      maze_we    <= we_d;
      busy       <= busy_d;
      done       <= done_d;
      fail       <= fail_d;
    end
  end

  assign step_count = step_q;

endmodule

// File: tb/tb_maze_walker.sv
// Scoreboard bench for maze_walker on an 8x8 maze.
// Second instance runs with a 5-move budget.
module tb_maze_walker;

  localparam int RW = 6;
  localparam int CW = 6;
  localparam int NR = 8;
  localparam int NC = 8;
  localparam int SW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_a, start_b;
  logic [RW-1:0] s_row;
  logic [CW-1:0] s_col;
  logic [1:0]    s_dir;
  logic          hand;

  logic          a_in, a_oe, a_we, a_busy, a_done, a_fail;
  logic [RW-1:0] a_row;
  logic [CW-1:0] a_col;
  logic [SW-1:0] a_step;
  logic          b_in, b_oe, b_we, b_busy, b_done, b_fail;
  logic [RW-1:0] b_row;
  logic [CW-1:0] b_col;
  logic [SW-1:0] b_step;

  logic wall [NR][NC];

  maze_walker #(
    .ROW_W(RW), .COL_W(CW), .MAZE_ROWS(NR), .MAZE_COLS(NC),
    .STEP_W(SW), .MAX_STEPS(4095)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .starting_row(s_row), .starting_col(s_col),
    .start_dir(s_dir), .hand_sel(hand), .maze_in(a_in),
    .row(a_row), .col(a_col), .maze_oe(a_oe), .maze_we(a_we),
    .busy(a_busy), .done(a_done), .fail(a_fail),
    .step_count(a_step)
  );

  maze_walker #(
    .ROW_W(RW), .COL_W(CW), .MAZE_ROWS(NR), .MAZE_COLS(NC),
    .STEP_W(SW), .MAX_STEPS(5)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .starting_row(s_row), .starting_col(s_col),
    .start_dir(s_dir), .hand_sel(hand), .maze_in(b_in),
    .row(b_row), .col(b_col), .maze_oe(b_oe), .maze_we(b_we),
    .busy(b_busy), .done(b_done), .fail(b_fail),
    .step_count(b_step)
  );

  // synchronous memory: data valid the cycle after oe
  always @(posedge clk) begin
    a_in <= (a_oe && a_row < NR && a_col < NC) ?
            wall[a_row[2:0]][a_col[2:0]] : 1'b1;
    b_in <= (b_oe && b_row < NR && b_col < NC) ?
            wall[b_row[2:0]][b_col[2:0]] : 1'b1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic          sel;
  logic          m_oe, m_we, m_done, m_fail, m_busy;
  logic [RW-1:0] m_row;
  logic [CW-1:0] m_col;
  logic [SW-1:0] m_step;
  assign m_oe   = sel ? b_oe   : a_oe;
  assign m_we   = sel ? b_we   : a_we;
  assign m_done = sel ? b_done : a_done;
  assign m_fail = sel ? b_fail : a_fail;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_row  = sel ? b_row  : a_row;
  assign m_col  = sel ? b_col  : a_col;
  assign m_step = sel ? b_step : a_step;

  logic [11:0] exp_q[$];
  int cyc = 0;
  int rd_cnt, we_cnt, last_we_cyc, done_cyc, fail_seen;
  int we_r, we_c;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_oe || m_we)
        check("oe_we_excl", {31'd0, m_oe & m_we}, 0);
      if (m_oe) begin
        int dr, dc;
        rd_cnt++;
        dr = int'(m_row) - we_r;
        dc = int'(m_col) - we_c;
        if (dr < 0) dr = -dr;
        if (dc < 0) dc = -dc;
        assert (dr + dc == 1 && m_row < NR && m_col < NC)
          else $error("probe address not adjacent to marked cell");
        check("probe_adj", dr + dc, 1);
      end
      if (m_we) begin
        we_cnt++;
        last_we_cyc = cyc;
        we_r = int'(m_row);
        we_c = int'(m_col);
        if (exp_q.size() == 0)
          check("we_q_empty", exp_q.size(), 1);
        else
          check("we_addr", {20'd0, m_row, m_col}, {20'd0, exp_q.pop_front()});
      end
      if (m_fail) fail_seen = 1;
      if (m_done && !prev_done) done_cyc = cyc;
      prev_done = m_done;
    end
  end

  task automatic push(int r, int c);
    exp_q.push_back({6'(r), 6'(c)});
  endtask

  task automatic fill(logic v);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        wall[r][c] = v;
  endtask

  task automatic load_corridor();
    fill(1'b1);
    for (int c = 3; c < NC; c++) wall[3][c] = 1'b0;
  endtask

  task automatic walk(logic use_b, int r, int c, int d, logic h,
                      output int lat);
    @(negedge clk);
    sel = use_b;
    rd_cnt = 0;
    we_cnt = 0;
    fail_seen = 0;
    done_cyc = -1;
    last_we_cyc = -100;
    s_row = RW'(r);
    s_col = CW'(c);
    s_dir = 2'(d);
    hand  = h;
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 1;
    while (!(m_done || m_fail) && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    #1;
    check("walk_end", {31'd0, m_done | m_fail}, 1);
  endtask

  int lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    s_row = '0;
    s_col = '0;
    s_dir = '0;
    hand = 1'b0;
    sel = 1'b0;
    we_r = 0;
    we_c = 0;
    load_corridor();
    repeat (3) @(negedge clk);
    check("rst_a", {a_busy, a_done, a_fail, a_oe, a_we, a_row, a_col, a_step}, 0);
    check("rst_b", {b_busy, b_done, b_fail, b_oe, b_we, b_row, b_col, b_step}, 0);
    rst = 1'b0;

    // straight corridor east, right hand
    for (int c = 3; c < NC; c++) push(3, c);
    walk(1'b0, 3, 3, 1, 1'b0, lat);
    check("s1_done", {31'd0, a_done}, 1);
    check("s1_fail", {31'd0, a_fail}, 0);
    check("s1_busy", {31'd0, a_busy}, 0);
    check("s1_steps", a_step, 4);
    check("s1_reads", rd_cnt, 8);
    check("s1_lat", lat, 22);
    check("s1_exit", {a_row, a_col}, {6'd3, 6'd7});
    check("s1_done_next", done_cyc, last_we_cyc + 1);
    check("s1_q", exp_q.size(), 0);

    // heading west, left hand: two turns at the dead end
    for (int c = 3; c < NC; c++) push(3, c);
    walk(1'b0, 3, 3, 3, 1'b1, lat);
    check("s2_done", {31'd0, a_done}, 1);
    check("s2_fail_seen", fail_seen, 0);
    check("s2_steps", a_step, 4);
    check("s2_reads", rd_cnt, 12);
    check("s2_exit", {a_row, a_col}, {6'd3, 6'd7});
    check("s2_q", exp_q.size(), 0);

    // enclosed cell
    fill(1'b1);
    wall[4][4] = 1'b0;
    push(4, 4);
    walk(1'b0, 4, 4, 1, 1'b0, lat);
    check("s3_fail", {31'd0, a_fail}, 1);
    check("s3_done", {31'd0, a_done}, 0);
    check("s3_steps", a_step, 0);
    check("s3_reads", rd_cnt, 6);
    check("s3_we", we_cnt, 1);
    check("s3_q", exp_q.size(), 0);

    // border start
    push(0, 5);
    walk(1'b0, 0, 5, 2, 1'b0, lat);
    check("s4_done", {31'd0, a_done}, 1);
    check("s4_steps", a_step, 0);
    check("s4_reads", rd_cnt, 0);
    check("s4_we", we_cnt, 1);
    check("s4_done_next", done_cyc, last_we_cyc + 1);
    check("s4_q", exp_q.size(), 0);

    // 2x2 loop with 5-move budget
    fill(1'b1);
    wall[2][2] = 1'b0;
    wall[2][3] = 1'b0;
    wall[3][2] = 1'b0;
    wall[3][3] = 1'b0;
    push(2, 2); push(3, 2); push(3, 3);
    push(2, 3); push(2, 2); push(3, 2);
    walk(1'b1, 2, 2, 1, 1'b0, lat);
    check("s5_fail", {31'd0, b_fail}, 1);
    check("s5_done", {31'd0, b_done}, 0);
    check("s5_steps", b_step, 5);
    check("s5_busy", {31'd0, b_busy}, 0);
    check("s5_q", exp_q.size(), 0);

    // reset in the middle of a walk
    load_corridor();
    push(3, 3);
    push(3, 4);
    @(negedge clk);
    sel = 1'b0;
    s_row = 6'd3;
    s_col = 6'd3;
    s_dir = 2'd1;
    hand = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    check("s6_busy_mid", {31'd0, a_busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("s6_rst_out",
          {a_busy, a_done, a_fail, a_oe, a_we, a_row, a_col, a_step}, 0);
    check("s6_q", exp_q.size(), 0);
    rst = 1'b0;
    for (int c = 3; c < NC; c++) push(3, c);
    walk(1'b0, 3, 3, 1, 1'b0, lat);
    check("s6_done", {31'd0, a_done}, 1);
    check("s6_steps", a_step, 4);
    check("s6_reads", rd_cnt, 8);
    check("s6_lat", lat, 22);
    check("s6_q2", exp_q.size(), 0);

    // start outside the maze
    walk(1'b0, 9, 3, 1, 1'b0, lat);
    check("s7_fail", {31'd0, a_fail}, 1);
    check("s7_done", {31'd0, a_done}, 0);
    check("s7_busy", {31'd0, a_busy}, 0);
    check("s7_reads", rd_cnt, 0);
    check("s7_we", we_cnt, 0);
    check("s7_lat", lat, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/maze_walker.md
Name: maze_walker

Overview:
- Parametrised wall-follower maze solver for rectangular mazes of configurable size.
- Selectable right-hand or left-hand rule and programmable start heading.
- Start/busy/done/fail handshake, bounded step budget, and enclosed-cell detection.
- Sits between the controller and the synchronous maze memory (1 = wall, 0 = free). Marks visited cells through the write port.

Parameters:
- ROW_W, 6, width of row address
- COL_W, 6, width of column address
- MAZE_ROWS, 64, number of rows; border rows are 0 and MAZE_ROWS-1
- MAZE_COLS, 64, number of columns; border columns are 0 and MAZE_COLS-1
- STEP_W, 12, width of step counter
- MAX_STEPS, 4095, move budget; exceeding it raises fail

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a walk; one-cycle pulse
- starting_row  in  ROW_W  start row, sampled on accepted start
- starting_col  in  COL_W  start column, sampled on accepted start
- start_dir  in  2  initial heading (N=0, E=1, S=2, W=3), sampled on start
- hand_sel  in  1  0 = right-hand rule, 1 = left-hand rule, sampled on start
- maze_in  in  1  read data; valid the cycle after maze_oe
- row  out  ROW_W  memory row address (registered)
- col  out  COL_W  memory column address (registered)
- maze_oe  out  1  read enable (registered)
- maze_we  out  1  write-visited enable (registered)
- busy  out  1  walk in progress
- done  out  1  exit reached; sticky
- fail  out  1  walk aborted; sticky
- step_count  out  STEP_W  moves made in the current or last walk

Behaviour:
- Reset: all outputs 0; state IDLE. Reset mid-walk aborts immediately; no further memory accesses.
- Direction arithmetic is mod 4. Side turn is +1 for the right hand, -1 for the left hand; away turn is the opposite.
- Neighbour of a heading: N row-1, E col+1, S row+1, W col-1.
- Start is accepted in IDLE, DONE or FAIL. On acceptance:
  - done, fail and step_count clear.
  - busy is set the next cycle.
  - start, heading and hand are latched; turn_cnt = 0.
- start is ignored while busy.
- If starting_row >= MAZE_ROWS or starting_col >= MAZE_COLS: go to FAIL, with no memory access.
- Memory timing: oe asserted with the address in cycle T; maze_in sampled at the end of T+1.
- oe and we are never high together, and are high for exactly one cycle per access.
- States:
  - MARK: we=1 at the current cell. If the cell is on the border, go to DONE; else go to PROBE_SIDE.
  - PROBE_SIDE: oe=1, address = side neighbour. Next state EVAL_SIDE.
  - EVAL_SIDE:
    - maze_in=0: heading = side; move to the side cell; step_count++; turn_cnt = 0; go to MARK.
    - maze_in=1: go to PROBE_FRONT.
  - PROBE_FRONT: oe=1, address = front neighbour. Next state EVAL_FRONT.
  - EVAL_FRONT:
    - maze_in=0: move forward; step_count++; turn_cnt = 0; go to MARK.
    - maze_in=1: heading = away turn; turn_cnt++. If turn_cnt reaches 3, go to FAIL (enclosed); else go to PROBE_SIDE.
  - DONE: done=1, busy=0. row/col hold the exit cell.
  - FAIL: fail=1, busy=0.
- Step budget: a move that would make step_count exceed MAX_STEPS goes to FAIL instead. step_count saturates at MAX_STEPS.
- Minimum cost per move: 3 cycles (side free) or 5 cycles (front free).
- Start on a border cell: the cell is marked, then done asserts the next cycle with step_count = 0.
- Neighbour addresses are only generated from interior cells, so no wrap-around can occur. This must be asserted in the bench.

Decomposition:
- Package maze_pkg:
  - dir_t (2-bit: N, E, S, W)
  - state_t enumeration
  - functions turn_side(dir, hand) and turn_away(dir, hand)
- Sub-module maze_neighbor: pure combinational (row, col, dir) -> neighbour (row, col), parametrised by ROW_W and COL_W. Instantiated once in the walker; the address mux selects between side and front directions.

Test Plan:
- 8x8 maze, straight free corridor east from (3,3) to (3,7), all else wall, start_dir=E, right hand -> we at (3,4), (3,5), (3,6), (3,7); done=1; step_count=4.
- Same maze, start (3,3), start_dir=W, left hand -> turns at dead end then walks east; done at (3,7); fail never asserts.
- Cell (4,4) with all four neighbours wall -> exactly 6 reads, then fail=1; step_count=0; we pulsed once, at (4,4).
- Start (0,5) -> single we at (0,5); done the next cycle; no oe pulses.
- MAX_STEPS=5, 2x2 free loop inside walls -> fail after move 5; step_count=5.
- rst asserted mid-walk, then start at (3,3) -> outputs 0 on the reset cycle; the new walk matches the first scenario exactly. starting_row=9 in an 8-row maze -> fail, no memory access.
